// File: rtl/framebuf_arbiter_if.sv
// framebuf_arbiter_if: groups the camera write channel, the VGA read channel
// and the frame-buffer BRAM port shared by framebuf_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding logic (camera writer, VGA reader and BRAM).
interface framebuf_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              cam_wr_valid;
  logic              cam_wr_ready;
  logic [ADDR_W-1:0] cam_wr_addr;
  logic [DATA_W-1:0] cam_wr_data;

  logic              vga_rd_req;
  logic [ADDR_W-1:0] vga_rd_addr;
  logic              vga_rd_valid;
  logic [DATA_W-1:0] vga_rd_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cam_wr_valid, cam_wr_addr, cam_wr_data,
    input  vga_rd_req, vga_rd_addr,
    input  mem_rdata,
    output cam_wr_ready, vga_rd_valid, vga_rd_data,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cam_wr_valid, cam_wr_addr, cam_wr_data,
    output vga_rd_req, vga_rd_addr,
    output mem_rdata,
    input  cam_wr_ready, vga_rd_valid, vga_rd_data,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/framebuf_arbiter.sv
// framebuf_arbiter: shares the single-port frame-buffer BRAM between the
// camera pixel writer and the VGA scan-out reader. Camera writes are parked
// in a small FIFO and drained in slots the VGA reader leaves free; VGA reads
// always win and return data a fixed three cycles after the request.
// frame_lock freezes the displayed frame by holding every FIFO entry.
// Optional feature: define FRAMEBUF_STATS_EN to add the 16-bit saturating
// wr_stall_cnt output counting cycles the camera is held off.
module framebuf_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk_in,
  input  logic rst,
  input  logic frame_lock,
  framebuf_arbiter_if.slave bus
`ifdef FRAMEBUF_STATS_EN
  ,
  output logic [15:0] wr_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] GNT_IDLE  = 2'd0;
  localparam logic [1:0] GNT_READ  = 2'd1;
  localparam logic [1:0] GNT_WRITE = 2'd2;

  logic [1:0]        gnt;
  logic [1:0]        gnt_next;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              rd_pending;

  // Ready comes from the registered count only, so a pop in the same cycle
  // does not let an extra pixel in; it is forced low while reset is held.
  assign bus.cam_wr_ready = !rst && (count != CNT_W'(FIFO_DEPTH));
  assign push             = bus.cam_wr_valid && bus.cam_wr_ready;
  assign pop              = (gnt_next == GNT_WRITE);

  // Pick next cycle's memory operation: VGA read first, then a FIFO drain.
  always_comb begin
    gnt_next = GNT_IDLE;
    if (bus.vga_rd_req)
      gnt_next = GNT_READ;
    else if ((count != '0) && !frame_lock)
      gnt_next = GNT_WRITE;
  end

  // FIFO storage; contents need no reset because the count gates them.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.cam_wr_addr;
      fifo_data[wr_ptr] <= bus.cam_wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
    end
  end

  // Registered BRAM port; address and data hold their values while idle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      gnt           <= GNT_IDLE;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      gnt <= gnt_next;
      case (gnt_next)
        GNT_READ: begin
          bus.mem_en   <= 1'b1;
          bus.mem_we   <= 1'b0;
          bus.mem_addr <= bus.vga_rd_addr;
        end
        GNT_WRITE: begin
          bus.mem_en    <= 1'b1;
          bus.mem_we    <= 1'b1;
          bus.mem_addr  <= fifo_addr[rd_ptr];
          bus.mem_wdata <= fifo_data[rd_ptr];
        end
        default: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Read return path: BRAM data lands one cycle after the read is driven
  // and is registered once more, giving a fixed three-cycle read latency.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rd_pending       <= 1'b0;
      bus.vga_rd_valid <= 1'b0;
      bus.vga_rd_data  <= '0;
    end else begin
      rd_pending       <= (gnt == GNT_READ);
      bus.vga_rd_valid <= rd_pending;
      if (rd_pending)
        bus.vga_rd_data <= bus.mem_rdata;
    end
  end

`ifdef FRAMEBUF_STATS_EN
  // Count cycles the camera offers a pixel that cannot be taken, saturating.
  always_ff @(posedge clk_in) begin
    if (rst)
      wr_stall_cnt <= '0;
    else if (bus.cam_wr_valid && !bus.cam_wr_ready && (wr_stall_cnt != 16'hFFFF))
      wr_stall_cnt <= wr_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/framebuf_arbiter.md
# framebuf_arbiter

Shares the single-port frame-buffer BRAM between the camera pixel writer and the VGA scan-out reader in the PiCamera top level. Camera writes are buffered in a small internal FIFO and drained into memory in cycles the VGA reader does not claim. VGA reads always win and have fixed latency, so scan-out never stalls. A freeze input holds all writes so the displayed frame can be frozen from a button or switch.

## Interface
- ADDR_W, 17: frame-buffer address width.
- DATA_W, 8: pixel width; matches the `rgb` output.
- FIFO_DEPTH, 4: write FIFO entries; must be a power of two, at least 2.

- clk_in  in  1  100 MHz system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cam_wr_valid  in  1  camera has a pixel to write.
- cam_wr_ready  out  1  FIFO can accept; transfer occurs when valid && ready.
- cam_wr_addr  in  ADDR_W  write address.
- cam_wr_data  in  DATA_W  write pixel.
- frame_lock  in  1  high: no FIFO entry is drained to memory.
- vga_rd_req  in  1  single-cycle read request.
- vga_rd_addr  in  ADDR_W  read address, sampled with vga_rd_req.
- vga_rd_valid  out  1  one-cycle strobe; vga_rd_data is valid.
- vga_rd_data  out  DATA_W  read pixel.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data; synchronous, 1-cycle latency.

## Operation
- Grant register `gnt` has three states: IDLE, READ, WRITE. It is evaluated every cycle and determines the memory operation driven in the next cycle.
- Priority each cycle:
  - vga_rd_req → READ.
  - else FIFO non-empty && !frame_lock → WRITE, popping the head entry.
  - else IDLE.
- Any state may move to any other state in one cycle. There is no dwell or minimum hold time.
- FIFO behaviour:
  - Push on cam_wr_valid && cam_wr_ready.
  - cam_wr_ready = (count != FIFO_DEPTH). It is derived from the registered count only, so a same-cycle pop does not raise ready.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- frame_lock high:
  - Writes are never granted.
  - The FIFO still accepts pixels until full, then cam_wr_ready drops.
  - When the lock is released, draining resumes the next cycle.
- Memory port is fully registered:
  - READ: mem_en=1, mem_we=0, mem_addr = latched vga_rd_addr.
  - WRITE: mem_en=1, mem_we=1, mem_addr/mem_wdata = popped entry.
  - IDLE: mem_en=0, mem_we=0; address and data hold their last values.
- Read-after-write hazards are not resolved. A read to an address with a pending FIFO write returns the old value. Tearing is accepted.
- Reset values:
  - cam_wr_ready=0 during reset, 1 on the first cycle after.
  - vga_rd_valid=0, vga_rd_data=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - gnt=IDLE, FIFO empty.
- Reset asserted mid-operation:
  - FIFO contents are discarded.
  - The in-flight read valid pipeline is cleared, so no vga_rd_valid strobe follows.
  - A memory write already driven that cycle completes in the BRAM; this is harmless.

## Timing
- Read latency:
  - vga_rd_req in cycle N → memory read driven in N+1.
  - mem_rdata arrives in N+2 and is registered into vga_rd_data.
  - vga_rd_valid=1 in N+3, fixed.
- Back-to-back reads every cycle are supported, giving one valid strobe per cycle. Writes starve during such bursts.
- Write latency with no contention:
  - Push in cycle N → FIFO entry visible N+1, grant decided in N+1.
  - mem_we=1 in N+2.
- Sustained throughput:
  - VGA pixel rate is 25 MHz, at most one read per 4 cycles, so the writer gets at least 3 of every 4 slots.
  - With FIFO_DEPTH=4, a camera writing at most one pixel per 2 cycles never sees cam_wr_ready low while frame_lock=0.

## Configuration
- FRAMEBUF_STATS_EN defined:
  - Adds output `wr_stall_cnt` (16 bits), reset to 0.
  - It increments every cycle cam_wr_valid && !cam_wr_ready.
  - It saturates at 16'hFFFF and is intended for the 7-segment display.
- Not defined: the port and counter are absent, with no other behavioural difference.

## Test plan
- Reset then idle: rst high for 3 cycles, then low with no requests → mem_en=0 throughout, cam_wr_ready=1 from the first cycle after reset, vga_rd_valid never asserted.
- Single read: mem_rdata models a BRAM returning address[7:0]; vga_rd_req with addr 0x00123 in cycle N → mem_en=1, we=0, addr=0x00123 in N+1; vga_rd_valid=1 and data=0x23 in N+3 only.
- Contention: push (0x00010, 0xAA) and assert vga_rd_req (0x00020) in the same cycle, then a read every cycle for 5 cycles → no write occurs during the read burst; write 0xAA@0x00010 appears in the first cycle after the burst ends.
- FIFO full under lock: frame_lock=1, cam_wr_valid=1 with data 1..6 → exactly 4 accepted, then cam_wr_ready=0; release lock → writes of 1,2,3,4 on consecutive cycles in order, then ready returns to 1.
- Reset mid-read: vga_rd_req in N, rst in N+1 → no vga_rd_valid in N+3, FIFO empty after reset.
- Stats (FRAMEBUF_STATS_EN): repeat the full-under-lock case holding valid for 10 stalled cycles → wr_stall_cnt=10.
